// File: rtl/jif_bus_pkg.sv
// jif_bus_pkg: shared definitions for the jif memory responder.
//   - MMIO word addresses (OUT_PORT, CYCLES, CON_TX, CON_STAT)
//   - CPU rw encodings (RW_READ / RW_WRITE)
//   - decode-select enum and the address decode helper
package jif_bus_pkg;

  localparam logic [31:0] OUT_PORT = 32'hFFFF_FF00;  // R/W output register
  localparam logic [31:0] CYCLES   = 32'hFFFF_FF04;  // RO cycle counter
  localparam logic [31:0] CON_TX   = 32'hFFFF_FF08;  // WO console push
  localparam logic [31:0] CON_STAT = 32'hFFFF_FF0C;  // RO console status

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT,
    SEL_CYC,
    SEL_CON,
    SEL_STAT,
    SEL_NONE
  } sel_t;

  // RAM occupies word addresses [0, ram_words); the MMIO window sits at the
  // top of the address space. Everything else decodes to SEL_NONE.
  function automatic sel_t decode_addr(input logic [31:0] addr,
                                       input logic [31:0] ram_words);
    sel_t sel;
    if (addr < ram_words) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        OUT_PORT: sel = SEL_OUT;
        CYCLES:   sel = SEL_CYC;
        CON_TX:   sel = SEL_CON;
        CON_STAT: sel = SEL_STAT;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/jif_mem_responder_if.sv
// jif_mem_responder_if: CPU memory bus between the cpu block (master) and
// the memory responder (slave).
//   address : word address, driven every cycle (no request strobe)
//   rw      : 1 = read, 0 = write
//   datao   : write data from the CPU
//   data    : registered read data back to the CPU (1-cycle latency)
interface jif_mem_responder_if;
  logic [31:0] address;
  logic        rw;
  logic [31:0] datao;
  logic [31:0] data;

  modport master (output address, output rw, output datao, input data);
  modport slave  (input address, input rw, input datao, output data);
endinterface

// File: rtl/jif_byte_fifo.sv
// jif_byte_fifo: synchronous FIFO used for the console byte path.
//   clk, reset  : clock, synchronous active-low reset (flushes everything)
//   push        : write push_data this cycle
//   push_data   : entry to store
//   pop         : consumer takes the head entry this cycle (ignored if empty)
//   head        : current head entry, 0 when empty
//   full, empty : occupancy flags
//   count       : number of stored entries
//   drop        : push rejected because the FIFO is full and nothing pops
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module jif_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the head slot at the same edge, so a push while full is
  // accepted when it coincides with a pop and the count stays at DEPTH.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jif_mem_responder.sv
// jif_mem_responder: far-end responder of the CPU memory bus.
// Serves word-addressed RAM plus an MMIO window (output port, cycle counter,
// console FIFO push, console status). One access every cycle.
//   clk, reset : clock, synchronous active-low reset
//   bus        : CPU bus (slave modport): address, rw, datao in; data out
//   out_port   : MMIO output register
//   con_data   : console FIFO head byte
//   con_valid  : console FIFO non-empty
//   con_ready  : console consumer ready
//   bus_err    : sticky out-of-range / dropped-push flag
// Console handshake: a byte transfers on a rising edge where con_valid and
// con_ready are both 1; con_data is held stable while con_valid=1 and
// con_ready=0, and con_valid never depends combinationally on con_ready.
// Build option: define JIF_CYCLE_COUNTER_EN to implement the cycle counter
// at 0xFFFF_FF04; otherwise reads of that address return 0 without error.
module jif_mem_responder
  import jif_bus_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  jif_mem_responder_if.slave  bus,
  output logic [31:0]         out_port,
  output logic [7:0]          con_data,
  output logic                con_valid,
  input  logic                con_ready,
  output logic                bus_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]               ram [DEPTH];
  logic [31:0]               rdata;
  logic [31:0]               rdata_q;
  sel_t                      sel;
  logic [AW-1:0]             idx;
  logic                      is_read;
  logic                      is_write;
  logic                      ram_we;
  logic                      con_push;
  logic                      con_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign sel      = decode_addr(bus.address, 32'(DEPTH));
  assign idx      = bus.address[AW-1:0];
  assign is_read  = (bus.rw == RW_READ);
  assign is_write = !is_read;
  assign ram_we   = is_write && (sel == SEL_RAM);
  assign con_push = is_write && (sel == SEL_CON);
  assign con_pop  = con_valid && con_ready;

  jif_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (con_push),
    .push_data (bus.datao[7:0]),
    .pop       (con_pop),
    .head      (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign con_valid = (fifo_count != '0);

`ifdef JIF_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  // RAM has no reset; a write presented during reset is suppressed.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      ram[idx] <= bus.datao;
    end
  end

  // Read mux. Write-only and out-of-range locations read as zero.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_RAM:  rdata = ram[idx];
      SEL_OUT:  rdata = out_port;
      SEL_CYC: begin
`ifdef JIF_CYCLE_COUNTER_EN
        rdata = cycle_cnt;
`else
        rdata = '0;
`endif
      end
      SEL_STAT: rdata = {28'b0, fifo_full, fifo_empty, 2'b0};
      default:  rdata = '0;
    endcase
  end

  // The RAM read samples ram[idx] before this edge's write lands
  // (read-first); data only updates on read cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q  <= '0;
      out_port <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (is_read) begin
        rdata_q <= rdata;
      end
      if (is_write && (sel == SEL_OUT)) begin
        out_port <= bus.datao;
      end
      if ((sel == SEL_NONE) || fifo_drop) begin
        bus_err <= 1'b1;
      end
    end
  end

  assign bus.data = rdata_q;

endmodule

// File: tb/tb_jif_mem_responder.sv
// tb_jif_mem_responder: self-checking bench for jif_mem_responder.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_jif_mem_responder;
  import jif_bus_pkg::*;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] out_port;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        bus_err;

  always #5 clk = ~clk;

  jif_mem_responder_if bus ();

  jif_mem_responder #(
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .out_port  (out_port),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .bus_err   (bus_err)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  con_q[$];
  logic [31:0] model_ram [int];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk, input logic [31:0] exp, input string name);
    logic [31:0] e;
    bus.rw      = rw;
    bus.address = addr;
    bus.datao   = wdata;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      e = exp_q.pop_front();
      check(name_q.pop_front(), bus.data, e);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    access(RW_WRITE, addr, wdata, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    access(RW_READ, addr, 32'h0, 1'b1, exp, name);
  endtask

  task automatic idle();
    access(RW_READ, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    reset = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr(CON_TX, {24'h0, b});
    con_q.push_back(b);
  endtask

  task automatic drain();
    con_ready = 1'b1;
    for (int i = 0; i < 12 && con_q.size() > 0; i++) begin
      if (con_valid) check("con_byte", {24'h0, con_data}, {24'h0, con_q.pop_front()});
      idle();
    end
    check("drain_left", con_q.size(), 0);
    check("drain_valid", {31'h0, con_valid}, 32'h0);
    con_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;

    bus.rw = RW_READ;
    bus.address = 32'h0;
    bus.datao = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    check("rst_data", bus.data, 32'h0);
    check("rst_out_port", out_port, 32'h0);
    check("rst_con_valid", {31'h0, con_valid}, 32'h0);
    check("rst_con_data", {24'h0, con_data}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);

    // Table of basic accesses.
    vecs[0]  = '{RW_WRITE, 32'd5,             32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{RW_READ,  32'd5,             32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{RW_WRITE, OUT_PORT,          32'h0000_0012, 1'b0, 32'h0};
    vecs[3]  = '{RW_READ,  OUT_PORT,          32'h0,         1'b1, 32'h0000_0012};
    vecs[4]  = '{RW_WRITE, 32'd0,             32'hA5A5_0001, 1'b0, 32'h0};
    vecs[5]  = '{RW_WRITE, 32'(DEPTH - 1),    32'h5A5A_FFFF, 1'b0, 32'h0};
    vecs[6]  = '{RW_READ,  32'd0,             32'h0,         1'b1, 32'hA5A5_0001};
    vecs[7]  = '{RW_READ,  32'(DEPTH - 1),    32'h0,         1'b1, 32'h5A5A_FFFF};
    vecs[8]  = '{RW_WRITE, CYCLES,            32'h0000_1234, 1'b0, 32'h0};
    vecs[9]  = '{RW_READ,  CON_TX,            32'h0,         1'b1, 32'h0};
    vecs[10] = '{RW_READ,  CON_STAT,          32'h0,         1'b1, 32'h0000_0004};
    vecs[11] = '{RW_WRITE, CON_STAT,          32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[12] = '{RW_READ,  CON_STAT,          32'h0,         1'b1, 32'h0000_0004};
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp,
             $sformatf("vec%0d", i));
    end
    check("vec_out_port", out_port, 32'h0000_0012);
    check("vec_bus_err", {31'h0, bus_err}, 32'h0);

    // Output port visible the cycle after the write.
    wr(OUT_PORT, 32'h0000_0077);
    check("out_port_next", out_port, 32'h0000_0077);
    rd(OUT_PORT, 32'h0000_0077, "out_port_rd");

    // Random RAM traffic against a reference model (keeps clear of 0..15).
    for (int i = 0; i < 16; i++) begin
      a = 32'($urandom_range(16, DEPTH - 2));
      d = $urandom;
      wr(a, d);
      model_ram[int'(a)] = d;
    end
    foreach (model_ram[k]) begin
      rd(32'(k), model_ram[k], "ram_rand");
    end

    // Cycle counter.
`ifdef JIF_CYCLE_COUNTER_EN
    begin
      logic [31:0] c0;
      logic [31:0] c1;
      access(RW_READ, CYCLES, 32'h0, 1'b0, 32'h0, "");
      c0 = bus.data;
      idle();
      idle();
      access(RW_READ, CYCLES, 32'h0, 1'b0, 32'h0, "");
      c1 = bus.data;
      check("cyc_diff", c1 - c0, 32'd3);
      dut.cycle_cnt = 32'hFFFF_FFFF;
      rd(CYCLES, 32'hFFFF_FFFF, "cyc_max");
      rd(CYCLES, 32'h0, "cyc_wrap");
    end
`else
    rd(CYCLES, 32'h0, "cyc_off0");
    idle();
    idle();
    rd(CYCLES, 32'h0, "cyc_off1");
`endif
    check("cyc_bus_err", {31'h0, bus_err}, 32'h0);

    // Console: fill, overflow, drain in order.
    do_reset();
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    push_byte(8'h44);
    check("con_valid_full", {31'h0, con_valid}, 32'h1);
    check("con_head_a", {24'h0, con_data}, 32'h41);
    rd(CON_STAT, 32'h0000_0008, "stat_full");
    check("err_before_drop", {31'h0, bus_err}, 32'h0);
    wr(CON_TX, 32'h45);
    check("err_after_drop", {31'h0, bus_err}, 32'h1);
    idle();
    check("con_head_hold", {24'h0, con_data}, 32'h41);
    drain();
    rd(CON_STAT, 32'h0000_0004, "stat_empty");

    // Simultaneous push and pop while full.
    do_reset();
    check("err_cleared", {31'h0, bus_err}, 32'h0);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    con_ready = 1'b1;
    check("pp_head", {24'h0, con_data}, {24'h0, con_q.pop_front()});
    push_byte(8'h05);
    con_ready = 1'b0;
    check("pp_bus_err", {31'h0, bus_err}, 32'h0);
    rd(CON_STAT, 32'h0000_0008, "pp_stat_full");
    drain();

    // Push while empty with ready high: no bypass.
    con_ready = 1'b1;
    check("ep_valid_before", {31'h0, con_valid}, 32'h0);
    wr(CON_TX, 32'h66);
    check("ep_valid_after", {31'h0, con_valid}, 32'h1);
    check("ep_data", {24'h0, con_data}, 32'h66);
    idle();
    check("ep_popped", {31'h0, con_valid}, 32'h0);
    con_ready = 1'b0;

    // Out-of-range read.
    rd(32'd5, 32'hDEAD_BEEF, "ram_kept");
    check("oor_err_before", {31'h0, bus_err}, 32'h0);
    rd(32'(DEPTH), 32'h0, "oor_read");
    check("oor_err_after", {31'h0, bus_err}, 32'h1);

    // Reset mid-stream.
    wr(32'd7, 32'h0000_1111);
    wr(OUT_PORT, 32'h0000_0055);
    push_byte(8'h31);
    push_byte(8'h32);
    check("mid_valid", {31'h0, con_valid}, 32'h1);
    check("mid_out_port", out_port, 32'h0000_0055);
    reset = 1'b0;
    wr(32'd7, 32'h0000_7777);
    reset = 1'b1;
    con_q.delete();
    check("mrst_con_valid", {31'h0, con_valid}, 32'h0);
    check("mrst_con_data", {24'h0, con_data}, 32'h0);
    check("mrst_bus_err", {31'h0, bus_err}, 32'h0);
    check("mrst_out_port", out_port, 32'h0);
    check("mrst_data", bus.data, 32'h0);
    rd(32'd7, 32'h0000_1111, "mrst_ram_suppressed");
    reset = 1'b0;
    wr(CON_TX, 32'h99);
    reset = 1'b1;
    check("mrst_push_lost", {31'h0, con_valid}, 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
